// File: rtl/exec_ctrl.sv
// exec_ctrl: 4-cycle fetch/decode/exec/writeback controller driving an external ALU.
// Ports: clk, reset (sync, active-high), run; mem_addr/mem_rdata (sync instruction memory);
// R1/R2/opcode/cin to the ALU, aluOut/flags from it; pc, psr, wb_en/wb_addr/wb_data, halted.
module exec_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_rdata,
  output logic [15:0] R1,
  output logic [15:0] R2,
  output logic [7:0]  opcode,
  output logic        cin,
  input  logic [15:0] aluOut,
  input  logic [4:0]  flags,
  output logic [15:0] pc,
  output logic [4:0]  psr,
  output logic        wb_en,
  output logic [3:0]  wb_addr,
  output logic [15:0] wb_data,
  output logic        halted
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, WB, HALT} state_t;
  // Bit k set: nibble k is a valid register/immediate ALU operation.
  localparam logic [15:0] ALU_SET = 16'h6EEE;
  // Bit k set: immediate form with op k sign-extends its immediate.
  localparam logic [15:0] SEXT_SET = 16'h4EA0;
  state_t state, next;
  logic [15:0] regs [16];
  logic [15:0] ir, result, r1_q, r2_q, r1_c;
  logic [4:0]  flg;
  logic [3:0]  op, rd, ext, rs, kind;
  logic [7:0]  imm, op_c;
  logic        alu_std, sh_reg, lshi, ashui, valid, do_wb, do_psr;
  assign op   = ir[15:12];
  assign rd   = ir[11:8];
  assign ext  = ir[7:4];
  assign rs   = ir[3:0];
  assign imm  = ir[7:0];
  assign kind = (op == 4'h0) ? ext : op;
  always_comb begin
    alu_std = (op != 4'h8) && ALU_SET[kind];
    sh_reg  = (op == 4'h8) && (ext == 4'h4 || ext == 4'hF);
    lshi    = (op == 4'h8) && (ext[3:1] == 3'b000);
    ashui   = (op == 4'h8) && (ext[3:1] == 3'b001);
    valid   = alu_std || sh_reg || lshi || ashui;
    do_wb   = valid && !(alu_std && kind == 4'hB);
    do_psr  = valid && !(alu_std && kind == 4'hD);
    op_c    = sh_reg ? ir[15:8] : lshi ? 8'h88 : ashui ? 8'h8F : alu_std ? {4'h0, kind} : 8'h00;
    r1_c    = (op == 4'h0 || sh_reg) ? regs[rs] :
              lshi  ? (ext[0] ? -{12'b0, rs} : {12'b0, rs}) :
              ashui ? {12'b0, rs} :
              SEXT_SET[op] ? {{8{imm[7]}}, imm} : {8'h00, imm};
    next    = state == FETCH  ? (run ? DECODE : FETCH) :
              state == DECODE ? (mem_rdata[15:12] == 4'hF ? HALT : EXEC) :
              state == EXEC   ? WB :
              state == WB     ? FETCH : HALT;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      ir     <= '0;
      result <= '0;
      r1_q   <= '0;
      r2_q   <= '0;
      psr    <= '0;
      flg    <= '0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      state <= next;
      if (state == DECODE) ir <= mem_rdata;
      if (state == EXEC) begin
        result <= aluOut;
        flg    <= flags;
        r1_q   <= r1_c;
        r2_q   <= regs[rd];
      end
      if (state == WB) begin
        if (do_wb) regs[rd] <= result;
        if (do_psr) psr <= flg;
        pc <= pc + 16'd1;
      end
    end
  end
  assign mem_addr = pc;
  assign R1       = (state == EXEC) ? r1_c : r1_q;
  assign R2       = (state == EXEC) ? regs[rd] : r2_q;
  assign opcode   = (state == EXEC) ? op_c : 8'h00;
  assign cin      = psr[0];
  assign wb_en    = (state == WB) && do_wb;
  assign wb_addr  = rd;
  assign wb_data  = result;
  assign halted   = (state == HALT);
endmodule
